// File: rtl/and_gate_seq_pkg.sv
// Shared types and helpers for the AND-gate self-test sequencer.
// Pure definitions: no latency and no flow control.
package and_gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Vector v drives a=v[1], b=v[0], so an AND gate is high only for v==3.
    function automatic logic exp_out(input logic [1:0] v);
        return v == 2'd3;
    endfunction

endpackage

// File: rtl/and_gate_sequencer_step_timer.sv
// Hold-period counter: o_last is high on the final cycle of each STEP_CYCLES window.
// Free-runs while i_clear is low and wraps itself at terminal count; no backpressure.
module step_timer #(
    parameter int STEP_CYCLES = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_last
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign o_last = (cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clear || o_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/and_gate_sequencer.sv
// Sweeps the AND gate through all four input vectors, holding each STEP_CYCLES cycles.
// Sweep takes 4*STEP_CYCLES busy cycles plus a one-cycle DONE; starts during a sweep are dropped.
module and_gate_sequencer
    import and_gate_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_gate_out,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_mask
);

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t                   state;
    logic [1:0]               vidx;
    logic [1:0]               vnext;
    logic                     last;
    logic                     timer_clear;
    logic [NUM_VECTORS-1:0]   mask_upd;

    assign vnext       = vidx + 2'd1;
    assign timer_clear = (state != DRIVE);

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (timer_clear),
        .o_last  (last)
    );

    // Mask including this cycle's sample, so o_pass can be registered alongside o_done.
    always_comb begin
        mask_upd       = o_fail_mask;
        mask_upd[vidx] = (i_gate_out != exp_out(vidx));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            vidx        <= 2'd0;
            o_a         <= 1'b0;
            o_b         <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_fail_mask <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state       <= DRIVE;
                        vidx        <= 2'd0;
                        o_a         <= 1'b0;
                        o_b         <= 1'b0;
                        o_busy      <= 1'b1;
                        o_pass      <= 1'b0;
                        o_fail_mask <= 4'b0000;
                    end
                end
                DRIVE: begin
                    if (last) begin
                        o_fail_mask <= mask_upd;
                        if (vidx == LAST_VEC) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            o_pass <= ~|mask_upd;
                        end else begin
                            vidx <= vnext;
                            o_a  <= vnext[1];
                            o_b  <= vnext[0];
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/and_gate_sequencer.md
Name: and_gate_sequencer

Overview:
Self-test controller for the 2-input AND gate datapath. It drives the gate's a/b inputs through all four input combinations, holds each for a fixed number of cycles, and samples the gate output at the end of each hold. It compares each sample against the expected a&b and reports a pass/fail summary with a per-vector failure mask. It sits beside the gate in a board-level top, replacing the manual switch stimulus.

Parameters:
STEP_CYCLES, 10, clock cycles each input vector is held; legal range 2..65535.
CNT_W, $clog2(STEP_CYCLES), width of the hold counter; derived, not overridden.

Ports:
i_clk  input  1  system clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  start request; level, sampled each cycle.
i_gate_out  input  1  output of the AND gate under test (its o_LED).
o_a  output  1  drives gate input a.
o_b  output  1  drives gate input b.
o_busy  output  1  high while a sweep is in progress.
o_done  output  1  one-cycle pulse when a sweep completes.
o_pass  output  1  sweep result; 1 = all four vectors matched.
o_fail_mask  output  4  bit v set if vector v mismatched.

Behaviour:
- One clock (i_clk); reset asynchronous, active-low (i_rst_n). Fixed.
- Reset values: state IDLE, o_a=0, o_b=0, o_busy=0, o_done=0, o_pass=0, o_fail_mask=4'b0000, vector index=0, hold counter=0.
- Vector encoding: index v in 0..3, o_a=v[1], o_b=v[0]; expected output = (v==3).
- FSM states: IDLE, DRIVE, DONE.
- IDLE: if i_start=1, the next edge enters DRIVE with v=0, cnt=0, o_busy=1, o_fail_mask cleared, o_pass=0. Otherwise hold. o_a/o_b keep their last values.
- DRIVE: cnt increments each cycle. On the cycle where cnt==STEP_CYCLES-1, i_gate_out is sampled at that edge and o_fail_mask[v] <= (i_gate_out != expected(v)). Then:
  - if v<3: v increments and cnt resets to 0.
  - if v==3: go to DONE.
- Each vector is presented for exactly STEP_CYCLES cycles. A sweep occupies 4*STEP_CYCLES cycles with o_busy=1.
- DONE: lasts one cycle with o_done=1 and o_busy=0. o_pass <= ~|final mask, registered so it is valid in the same cycle as o_done. Then return to IDLE.
- o_pass and o_fail_mask are held until the next accepted start.
- i_start while busy or in DONE is ignored; no queuing.
- i_start held continuously re-triggers a sweep on the first IDLE cycle after DONE, so back-to-back sweeps are separated by exactly one IDLE cycle.
- Reset asserted mid-sweep: immediately returns all outputs to reset values. No o_done is generated for the aborted sweep.
- i_gate_out is treated as combinational from o_a/o_b. With STEP_CYCLES>=2, at least one settle cycle precedes sampling.
- The counter compares at STEP_CYCLES-1 and never wraps beyond it.

Decomposition:
- Package and_gate_seq_pkg contains:
  - the state enum (IDLE, DRIVE, DONE)
  - localparam NUM_VECTORS=4
  - function exp_out(v) returning v==3
- One natural sub-module: step_timer (parameter STEP_CYCLES). Ports: i_clk, i_rst_n, i_clear, o_last. It holds the counter and the terminal-count flag.
- A separate top, and_gate_selftest_top, instantiates and_gate_sequencer and and_gate. Keep the top outside this block.

Test Plan:
- STEP_CYCLES=10, correct gate, i_start pulsed 1 cycle -> o_a/o_b sequence 00,01,10,11 with 10 cycles each; o_busy high 40 cycles; o_done one cycle at cycle 41; o_pass=1; o_fail_mask=0000.
- Gate model forced to output OR instead of AND -> o_pass=0, o_fail_mask=0110.
- Gate output stuck at 0 -> o_pass=0, o_fail_mask=1000; stuck at 1 -> o_fail_mask=0111.
- i_rst_n asserted at cycle 25 of a sweep -> outputs return to 0 asynchronously, no o_done. Restart then yields a full clean 40-cycle sweep.
- i_start held high for 100 cycles -> two sweeps; second o_busy rises exactly 2 cycles after first o_done. Extra start pulses during busy are ignored.
- STEP_CYCLES=2 -> each vector held 2 cycles, o_done at cycle 9, correct mask.
